// File: rtl/map_pkg.sv
// Shared types, cell codes and index helpers for the game-map owner.
// Pure declarations; no latency or flow-control behaviour of its own.
package map_pkg;

   localparam int GRID   = 14;
   localparam int CELL_W = 4;
   localparam int MAP_W  = GRID * GRID * CELL_W;

   localparam logic [CELL_W-1:0] EMPTY_CODE = 4'b0000;
   localparam logic [CELL_W-1:0] P1_CODE    = 4'b0001;
   localparam logic [CELL_W-1:0] P2_CODE    = 4'b0010;
   localparam logic [CELL_W-1:0] P3_CODE    = 4'b0011;
   localparam logic [CELL_W-1:0] P4_CODE    = 4'b0100;
   localparam logic [CELL_W-1:0] WALL_CODE  = 4'b0101;
   localparam logic [CELL_W-1:0] GOAL_CODE  = 4'b0110;

   typedef enum logic [1:0] {
      CMD_PASS   = 2'b00,
      CMD_MOVE   = 2'b01,
      CMD_ADD    = 2'b10,
      CMD_REMOVE = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_RANGE = 2'b01,
      ERR_SRC   = 2'b10,
      ERR_DST   = 2'b11
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHECK     = 3'd1,
      ST_WRITE_SRC = 3'd2,
      ST_WRITE_DST = 3'd3,
      ST_PUBLISH   = 3'd4
   } state_e;

   // y*14+x tops out at 15*14+15 = 225, so 8 bits never wrap.
   function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y);
      return 8'(y) * 8'(GRID) + 8'(x);
   endfunction

   function automatic logic [9:0] cell_offset(input logic [3:0] x, input logic [3:0] y);
      return {cell_index(x, y), 2'b00};
   endfunction

   function automatic logic in_grid(input logic [3:0] v);
      return v < 4'(GRID);
   endfunction

   // Standard start layout: players in the corners, goal at (7,7), ten movable walls.
   function automatic logic [MAP_W-1:0] start_map();
      logic [MAP_W-1:0] m;
      m = '0;
      m[cell_offset(4'd0,  4'd0 ) +: CELL_W] = P1_CODE;
      m[cell_offset(4'd13, 4'd0 ) +: CELL_W] = P2_CODE;
      m[cell_offset(4'd0,  4'd13) +: CELL_W] = P3_CODE;
      m[cell_offset(4'd13, 4'd13) +: CELL_W] = P4_CODE;
      m[cell_offset(4'd7,  4'd7 ) +: CELL_W] = GOAL_CODE;
      m[cell_offset(4'd5,  4'd0 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd8,  4'd0 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd0,  4'd5 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd13, 4'd5 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd0,  4'd8 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd13, 4'd8 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd5,  4'd13) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd8,  4'd13) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd6,  4'd7 ) +: CELL_W] = WALL_CODE;
      m[cell_offset(4'd7,  4'd6 ) +: CELL_W] = WALL_CODE;
      return m;
   endfunction

endpackage

// File: rtl/map_updater_if.sv
// Gamemaster-to-map-owner command bus plus the published map and status.
// No flow control: commands are edge-triggered, results are strobed with new_data.
interface map_updater_if;
   import map_pkg::*;

   logic             gm_done;
   logic [1:0]       gm_command;
   logic [3:0]       wallx_in;
   logic [3:0]       wally_in;
   logic [3:0]       wallx_out;
   logic [3:0]       wally_out;
   logic [MAP_W-1:0] map_data;
   logic             new_data;
   logic             busy;
   logic             cmd_error;
   logic [1:0]       err_code;

   modport master (
      output gm_done, gm_command, wallx_in, wally_in, wallx_out, wally_out,
      input  map_data, new_data, busy, cmd_error, err_code
   );

   modport slave (
      input  gm_done, gm_command, wallx_in, wally_in, wallx_out, wally_out,
      output map_data, new_data, busy, cmd_error, err_code
   );

endinterface

// File: rtl/map_cell_rw.sv
// Map storage: two combinational cell reads (source, destination) and one registered cell write.
// Write lands on the clock edge after wr_en; reset reloads INIT_MAP and overrides any write.
module map_cell_rw
   import map_pkg::*;
#(
   parameter logic [MAP_W-1:0] INIT_MAP = '0
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [3:0]        src_x,
   input  logic [3:0]        src_y,
   input  logic [3:0]        dst_x,
   input  logic [3:0]        dst_y,
   output logic [CELL_W-1:0] src_cell,
   output logic [CELL_W-1:0] dst_cell,
   input  logic              wr_en,
   input  logic [3:0]        wr_x,
   input  logic [3:0]        wr_y,
   input  logic [CELL_W-1:0] wr_code,
   output logic [MAP_W-1:0]  map
);

   // Off-grid reads return EMPTY so the part-select never leaves the vector.
   function automatic logic [CELL_W-1:0] read_cell(input logic [MAP_W-1:0] m,
                                                   input logic [3:0] x,
                                                   input logic [3:0] y);
      if (in_grid(x) && in_grid(y)) begin
         return m[cell_offset(x, y) +: CELL_W];
      end
      return EMPTY_CODE;
   endfunction

   assign src_cell = read_cell(map, src_x, src_y);
   assign dst_cell = read_cell(map, dst_x, dst_y);

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         map <= INIT_MAP;
      end else if (wr_en && in_grid(wr_x) && in_grid(wr_y)) begin
         map[cell_offset(wr_x, wr_y) +: CELL_W] <= wr_code;
      end
   end

endmodule

// File: rtl/map_updater.sv
// Validates and applies one gamemaster wall command to the 14x14 map, then strobes new_data.
// new_data 4 cycles after gm_done rises (2 on error/pass); edges while busy are dropped, no queueing.
module map_updater
   import map_pkg::*;
#(
   parameter logic [MAP_W-1:0] INIT_MAP = start_map()
) (
   input logic          CLOCK_50,
   input logic          reset,
   map_updater_if.slave bus
);

   state_e            state;
   cmd_e              cmd_q;
   logic [3:0]        sx_q, sy_q, dx_q, dy_q;
   logic              prev_done;
   logic              new_data_q;
   logic              busy_q;
   logic              cmd_error_q;
   err_e              err_q;

   logic [CELL_W-1:0] src_cell, dst_cell;
   logic [MAP_W-1:0]  map;
   logic              wr_en;
   logic [3:0]        wr_x, wr_y;
   logic [CELL_W-1:0] wr_code;

   logic              uses_src, uses_dst;
   logic              range_bad, src_bad, dst_bad;
   err_e              chk_err;

   map_cell_rw #(
      .INIT_MAP (INIT_MAP)
   ) u_cell_rw (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .src_x    (sx_q),
      .src_y    (sy_q),
      .dst_x    (dx_q),
      .dst_y    (dy_q),
      .src_cell (src_cell),
      .dst_cell (dst_cell),
      .wr_en    (wr_en),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_code  (wr_code),
      .map      (map)
   );

   assign uses_src = (cmd_q == CMD_MOVE) || (cmd_q == CMD_REMOVE);
   assign uses_dst = (cmd_q == CMD_MOVE) || (cmd_q == CMD_ADD);

   assign range_bad = (uses_src && !(in_grid(sx_q) && in_grid(sy_q))) ||
                      (uses_dst && !(in_grid(dx_q) && in_grid(dy_q)));
   assign src_bad   = uses_src && (src_cell != WALL_CODE);
   assign dst_bad   = uses_dst && (dst_cell != EMPTY_CODE);

   always_comb begin
      chk_err = ERR_NONE;
      if (range_bad) begin
         chk_err = ERR_RANGE;
      end else if (src_bad) begin
         chk_err = ERR_SRC;
      end else if (dst_bad) begin
         chk_err = ERR_DST;
      end
   end

   // The single write port is steered to the source or destination by state.
   always_comb begin
      wr_en   = 1'b0;
      wr_x    = dx_q;
      wr_y    = dy_q;
      wr_code = WALL_CODE;
      if (state == ST_WRITE_SRC) begin
         wr_en   = uses_src;
         wr_x    = sx_q;
         wr_y    = sy_q;
         wr_code = EMPTY_CODE;
      end else if (state == ST_WRITE_DST) begin
         wr_en   = uses_dst;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cmd_q       <= CMD_PASS;
         sx_q        <= '0;
         sy_q        <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         prev_done   <= 1'b0;
         new_data_q  <= 1'b1;
         busy_q      <= 1'b0;
         cmd_error_q <= 1'b0;
         err_q       <= ERR_NONE;
      end else begin
         prev_done  <= bus.gm_done;
         new_data_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.gm_done && !prev_done) begin
                  cmd_q  <= cmd_e'(bus.gm_command);
                  sx_q   <= bus.wallx_in;
                  sy_q   <= bus.wally_in;
                  dx_q   <= bus.wallx_out;
                  dy_q   <= bus.wally_out;
                  busy_q <= 1'b1;
                  state  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (cmd_q == CMD_PASS || chk_err == ERR_NONE) begin
                  cmd_error_q <= 1'b0;
                  err_q       <= ERR_NONE;
               end else begin
                  cmd_error_q <= 1'b1;
                  err_q       <= chk_err;
               end
               if (cmd_q == CMD_PASS || chk_err != ERR_NONE) begin
                  new_data_q <= 1'b1;
                  state      <= ST_PUBLISH;
               end else begin
                  state      <= ST_WRITE_SRC;
               end
            end
            ST_WRITE_SRC: begin
               state <= ST_WRITE_DST;
            end
            ST_WRITE_DST: begin
               new_data_q <= 1'b1;
               state      <= ST_PUBLISH;
            end
            ST_PUBLISH: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.map_data  = map;
   assign bus.new_data  = new_data_q;
   assign bus.busy      = busy_q;
   assign bus.cmd_error = cmd_error_q;
   assign bus.err_code  = err_q;

endmodule

// File: tb/tb_map_updater.sv
// Randomized and directed bench for map_updater against a grid-array reference model.
module tb_map_updater;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   map_updater_if bus ();

   map_updater dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   int checks = 0;
   int passed = 0;

   logic [3:0] mdl [14][14];
   int         mdl_err = 0;

   function automatic void model_init();
      for (int y = 0; y < 14; y++)
         for (int x = 0; x < 14; x++)
            mdl[y][x] = 4'd0;
      mdl[0][0]   = 4'd1;  mdl[0][13]  = 4'd2;
      mdl[13][0]  = 4'd3;  mdl[13][13] = 4'd4;
      mdl[7][7]   = 4'd6;
      mdl[0][5]   = 4'd5;  mdl[0][8]   = 4'd5;
      mdl[5][0]   = 4'd5;  mdl[5][13]  = 4'd5;
      mdl[8][0]   = 4'd5;  mdl[8][13]  = 4'd5;
      mdl[13][5]  = 4'd5;  mdl[13][8]  = 4'd5;
      mdl[7][6]   = 4'd5;  mdl[6][7]   = 4'd5;
      mdl_err = 0;
   endfunction

   function automatic logic [783:0] model_map();
      logic [783:0] m;
      m = '0;
      for (int y = 0; y < 14; y++)
         for (int x = 0; x < 14; x++)
            m[(y * 14 + x) * 4 +: 4] = mdl[y][x];
      return m;
   endfunction

   // Returns the expected error code and applies the move to the model when legal.
   function automatic int model_apply(input int c, input int sx, input int sy,
                                      input int dx, input int dy);
      bit us, ud;
      us = (c == 1) || (c == 3);
      ud = (c == 1) || (c == 2);
      if (c == 0) return 0;
      if ((us && (sx >= 14 || sy >= 14)) || (ud && (dx >= 14 || dy >= 14))) return 1;
      if (us && mdl[sy][sx] != 4'd5) return 2;
      if (ud && mdl[dy][dx] != 4'd0) return 3;
      if (us) mdl[sy][sx] = 4'd0;
      if (ud) mdl[dy][dx] = 4'd5;
      return 0;
   endfunction

   task automatic send_cmd(input int c, input int sx, input int sy, input int dx, input int dy,
                           output int lat, output int pulses, output logic busy_pub);
      @(negedge CLOCK_50);
      bus.gm_command = 2'(c);
      bus.wallx_in   = 4'(sx);
      bus.wally_in   = 4'(sy);
      bus.wallx_out  = 4'(dx);
      bus.wally_out  = 4'(dy);
      bus.gm_done    = 1'b1;
      lat = 0; pulses = 0; busy_pub = 1'b0;
      @(posedge CLOCK_50);
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLOCK_50);
         if (k == 1) bus.gm_done = 1'b0;
         if (bus.new_data === 1'b1) begin
            pulses++;
            if (lat == 0) begin
               lat = k;
               busy_pub = bus.busy;
            end
         end
      end
   endtask

   task automatic test_reset();
      model_init();
      bus.gm_done = 1'b0; bus.gm_command = 2'd0;
      bus.wallx_in = 4'd0; bus.wally_in = 4'd0; bus.wallx_out = 4'd0; bus.wally_out = 4'd0;
      reset = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b1;
      #1;
      checks++; if (bus.map_data !== model_map()) $display("FAIL reset_map got=%h exp=%h", bus.map_data, model_map()); else passed++;
      checks++; if (bus.new_data !== 1'b1) $display("FAIL reset_new_data got=%b exp=1", bus.new_data); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
      checks++; if (bus.err_code !== 2'd0 || bus.cmd_error !== 1'b0)
         $display("FAIL reset_err got=%b/%b exp=00/0", bus.err_code, bus.cmd_error); else passed++;
      @(negedge CLOCK_50);
      checks++; if (bus.new_data !== 1'b0) $display("FAIL reset_pulse_width got=%b exp=0", bus.new_data); else passed++;
   endtask

   // Errors first, then REMOVE/ADD at (5,0) so the later MOVE still finds a wall there.
   task automatic test_commands();
      int tbl [7][5] = '{'{1, 4, 0, 3, 0}, '{2, 0, 0, 14, 2}, '{2, 0, 0, 0, 0},
                         '{3, 5, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{2, 0, 0, 5, 0},
                         '{1, 5, 0, 3, 0}};
      int exp_err, exp_lat, lat, pulses;
      logic bp;
      for (int i = 0; i < 7; i++) begin
         exp_err = model_apply(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4]);
         exp_lat = (exp_err != 0 || tbl[i][0] == 0) ? 2 : 4;
         send_cmd(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], lat, pulses, bp);
         checks++; if (lat != exp_lat) $display("FAIL cmd%0d_latency got=%0d exp=%0d", i, lat, exp_lat); else passed++;
         checks++; if (pulses != 1 || bp !== 1'b1) $display("FAIL cmd%0d_pulse got=%0d busy=%b exp=1 busy=1", i, pulses, bp); else passed++;
         checks++; if (bus.err_code !== 2'(exp_err) || bus.cmd_error !== (exp_err != 0))
            $display("FAIL cmd%0d_err got=%b/%b exp=%0d", i, bus.err_code, bus.cmd_error, exp_err); else passed++;
         checks++; if (bus.map_data !== model_map()) $display("FAIL cmd%0d_map got=%h exp=%h", i, bus.map_data, model_map()); else passed++;
      end
      checks++; if (bus.map_data[(0 * 14 + 3) * 4 +: 4] !== 4'b0101 || bus.map_data[(0 * 14 + 5) * 4 +: 4] !== 4'b0000)
         $display("FAIL move_cells got=%b,%b exp=0101,0000", bus.map_data[12 +: 4], bus.map_data[20 +: 4]); else passed++;
   endtask

   task automatic test_move_onto_self();
      int lat, pulses, exp_err;
      logic bp;
      exp_err = model_apply(1, 8, 0, 8, 0);
      send_cmd(1, 8, 0, 8, 0, lat, pulses, bp);
      checks++; if (bus.err_code !== 2'(exp_err) || lat != 2)
         $display("FAIL self_move got=%b lat=%0d exp=%0d lat=2", bus.err_code, lat, exp_err); else passed++;
   endtask

   task automatic test_hold_and_busy();
      int pulses = 0, lat = 0, exp_err;
      exp_err = model_apply(2, 0, 0, 2, 2);
      @(negedge CLOCK_50);
      bus.gm_command = 2'd2; bus.wallx_out = 4'd2; bus.wally_out = 4'd2; bus.gm_done = 1'b1;
      @(posedge CLOCK_50);
      for (int k = 1; k <= 24; k++) begin
         @(negedge CLOCK_50);
         if (k == 1) begin
            bus.gm_done = 1'b0;
            bus.wallx_out = 4'd3; bus.wally_out = 4'd3;
         end
         if (k == 2) bus.gm_done = 1'b1;
         if (bus.new_data === 1'b1) begin
            pulses++;
            if (lat == 0) lat = k;
         end
      end
      bus.gm_done = 1'b0;
      checks++; if (pulses != 1 || lat != 4) $display("FAIL hold_pulses got=%0d lat=%0d exp=1 lat=4", pulses, lat); else passed++;
      checks++; if (bus.map_data !== model_map() || exp_err != 0) $display("FAIL hold_map got=%h exp=%h", bus.map_data, model_map()); else passed++;
      checks++; if (bus.busy !== 1'b0) $display("FAIL hold_busy got=%b exp=0", bus.busy); else passed++;
   endtask

   task automatic test_reset_mid_write();
      @(negedge CLOCK_50);
      bus.gm_command = 2'd1; bus.wallx_in = 4'd13; bus.wally_in = 4'd5;
      bus.wallx_out = 4'd12; bus.wally_out = 4'd5; bus.gm_done = 1'b1;
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      bus.gm_done = 1'b0;
      @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      reset = 1'b1;
      model_init();
      #1;
      checks++; if (bus.map_data !== model_map()) $display("FAIL midreset_map got=%h exp=%h", bus.map_data, model_map()); else passed++;
      checks++; if (bus.new_data !== 1'b1 || bus.busy !== 1'b0 || bus.err_code !== 2'd0)
         $display("FAIL midreset_status got=%b%b%b exp=1 0 00", bus.new_data, bus.busy, bus.err_code); else passed++;
   endtask

   task automatic test_random();
      int c, sx, sy, dx, dy, exp_err, exp_lat, lat, pulses;
      logic bp;
      for (int i = 0; i < 40; i++) begin
         c  = $urandom_range(0, 3);
         sx = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13);
         sy = $urandom_range(0, 13);
         dx = $urandom_range(0, 13);
         dy = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13);
         if ($urandom_range(0, 2) != 0) begin
            for (int t = 0; t < 40 && !(sx < 14 && mdl[sy][sx] == 4'd5); t++) begin
               sx = $urandom_range(0, 13);
               sy = $urandom_range(0, 13);
            end
         end
         exp_err = model_apply(c, sx, sy, dx, dy);
         exp_lat = (exp_err != 0 || c == 0) ? 2 : 4;
         send_cmd(c, sx, sy, dx, dy, lat, pulses, bp);
         checks++; if (lat != exp_lat || pulses != 1)
            $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d/1", i, lat, pulses, exp_lat); else passed++;
         checks++; if (bus.err_code !== 2'(exp_err) || bus.map_data !== model_map())
            $display("FAIL rand%0d_result err=%b exp=%0d map_ok=%b", i, bus.err_code, exp_err, bus.map_data === model_map()); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_commands();
      test_move_onto_self();
      test_hold_and_busy();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
